// File: rtl/data_mem_resp_if.sv
// Core-to-memory data port: byte address, access size, store data, load/store strobes
// going in; load data, stall and error pulse coming back.
interface data_mem_resp_if;
    logic [31:0] mem_addr;
    logic [1:0]  mem_byte_sel;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        halt;
    logic        err;

    modport master (
        output mem_addr, mem_byte_sel, mem_wdata, mem_we, mem_re,
        input  mem_rdata, halt, err
    );

    modport slave (
        input  mem_addr, mem_byte_sel, mem_wdata, mem_we, mem_re,
        output mem_rdata, halt, err
    );
endinterface

// File: rtl/data_mem_resp.sv
// Data-side memory responder: synchronous-read word SRAM with lane-aligned loads,
// single-cycle word stores and read-modify-write for byte/halfword stores.
module data_mem_resp #(
    parameter int ADDR_W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_resp_if.slave bus
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_RMW  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:0]         r_mem [0:(2**ADDR_W)-1];
    logic [31:0]         r_word;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic [ADDR_W-1:0]   w_idx;
    logic [1:0]          w_lane;
    logic                w_req;
    logic                w_illegal;
    logic                w_halt;
    logic                w_rd_issue;
    logic                w_wr_en;
    logic [31:0]         w_wr_data;
    logic                w_err_set;

    function automatic logic illegal_f(
        input logic [31:0] addr,
        input logic [1:0]  sel,
        input logic        we,
        input logic        re
    );
        logic bad;
        case (sel)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr[0];
            SZ_W:    bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if ((|addr[31:ADDR_W+2]) || (we && re)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    function automatic logic [31:0] merge_f(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  sel,
        input logic [1:0]  lane
    );
        logic [31:0] m;
        m = word;
        case (sel)
            SZ_B: begin
                case (lane)
                    2'd0:    m[7:0]   = wdata[7:0];
                    2'd1:    m[15:8]  = wdata[7:0];
                    2'd2:    m[23:16] = wdata[7:0];
                    default: m[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                if (lane[1]) begin
                    m[31:16] = wdata[15:0];
                end else begin
                    m[15:0] = wdata[15:0];
                end
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign w_idx     = bus.mem_addr[ADDR_W+1:2];
    assign w_lane    = bus.mem_addr[1:0];
    assign w_req     = bus.mem_we | bus.mem_re;
    assign w_illegal = illegal_f(bus.mem_addr, bus.mem_byte_sel, bus.mem_we, bus.mem_re);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: only legal loads and sub-word stores leave IDLE, for exactly one cycle
    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_illegal && !(bus.mem_we && bus.mem_byte_sel == SZ_W)) begin
                    w_next = bus.mem_we ? S_RMW : S_RD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RD:    w_next = S_IDLE;
            S_RMW:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs per state: stall, array read/write controls, error trigger
    always_comb begin
        w_halt     = 1'b0;
        w_rd_issue = 1'b0;
        w_wr_en    = 1'b0;
        w_wr_data  = bus.mem_wdata;
        w_err_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_req) begin
                    w_halt = 1'b0;
                end else if (w_illegal) begin
                    w_err_set = 1'b1;
                end else if (bus.mem_we && bus.mem_byte_sel == SZ_W) begin
                    w_wr_en = 1'b1;
                end else begin
                    w_halt     = 1'b1;
                    w_rd_issue = 1'b1;
                end
            end
            S_RMW: begin
                w_wr_en   = 1'b1;
                w_wr_data = merge_f(r_word, bus.mem_wdata, bus.mem_byte_sel, w_lane);
            end
            S_RD:    w_halt = 1'b0;
            default: w_halt = 1'b0;
        endcase
    end

    // Word array: write port gated by reset so an abandoned RMW never lands
    always_ff @(posedge clk) begin
        if (w_wr_en && rst_n) begin
            r_mem[w_idx] <= w_wr_data;
        end
        if (w_rd_issue) begin
            r_word <= r_mem[w_idx];
        end
    end

    // Load data and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (w_err_set) begin
                r_rdata <= 32'd0;
            end else if (w_rd_issue && bus.mem_re) begin
                r_rdata <= r_mem[w_idx] >> {w_lane, 3'b000};
            end
        end
    end

    assign bus.halt      = w_halt & rst_n;
    assign bus.err       = r_err;
    assign bus.mem_rdata = r_rdata;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed table, reset-during-RMW sequence,
// and randomized accesses checked against a word-array reference model.
module tb_data_mem_resp;

    logic clk;
    logic rst_n;
    data_mem_resp_if bus();

    data_mem_resp #(.ADDR_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [0:22];
    logic [31:0] mdl [0:1023];
    int          checks;
    int          errors;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] got_rd;

    // Core-side protocol: inputs must stay put while the responder is mid-access
    logic        sv_halt;
    logic [31:0] sv_addr;
    logic [31:0] sv_wd;
    logic [1:0]  sv_sel;
    logic        sv_we;
    logic        sv_re;
    always @(posedge clk) begin
        sv_halt <= bus.halt;
        sv_addr <= bus.mem_addr;
        sv_wd   <= bus.mem_wdata;
        sv_sel  <= bus.mem_byte_sel;
        sv_we   <= bus.mem_we;
        sv_re   <= bus.mem_re;
    end
    always @(negedge clk) begin
        if (sv_halt && rst_n) begin
            assert (bus.mem_addr == sv_addr && bus.mem_wdata == sv_wd &&
                    bus.mem_byte_sel == sv_sel && bus.mem_we == sv_we && bus.mem_re == sv_re)
            else $error("protocol violation: core inputs changed during stall");
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic eh);
        @(negedge clk);
        check("halt", {31'd0, bus.halt}, {31'd0, eh});
        check("err", {31'd0, bus.err}, {31'd0, exp_err});
        check("rdata", bus.mem_rdata, exp_rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd);
        bus.mem_we       = we;
        bus.mem_re       = re;
        bus.mem_byte_sel = sel;
        bus.mem_addr     = addr;
        bus.mem_wdata    = wd;
    endtask

    // Reference: legality from size/alignment/range rules, then one or two cycles
    task automatic acc(input logic we, input logic re, input logic [1:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd);
        int          nbytes;
        int          sh;
        logic        bad;
        logic [31:0] mask;
        drive(we, re, sel, addr, wd);
        nbytes = 1 << sel;
        sh     = 8 * int'(addr % 4);
        bad    = (sel == 2'd3) || ((addr % nbytes) != 0) || (addr >= 32'd4096) || (we && re);
        if (!(we || re)) begin
            cyc(1'b0);
            exp_err = 1'b0;
        end else if (bad) begin
            cyc(1'b0);
            exp_err   = 1'b1;
            exp_rdata = 32'd0;
        end else if (re) begin
            cyc(1'b1);
            exp_err   = 1'b0;
            exp_rdata = mdl[addr / 4] >> sh;
            cyc(1'b0);
            got_rd = bus.mem_rdata;
        end else if (sel == 2'd2) begin
            cyc(1'b0);
            exp_err        = 1'b0;
            mdl[addr / 4]  = wd;
        end else begin
            cyc(1'b1);
            exp_err = 1'b0;
            cyc(1'b0);
            mask = (sel == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
            mdl[addr / 4] = (mdl[addr / 4] & ~(mask << sh)) | ((wd & mask) << sh);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_err   = 1'b0;
        exp_rdata = 32'd0;
        got_rd    = 32'd0;
        rst_n     = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 2'd2, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 2'd2, 32'h20, 32'h11223344, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 32'h22, 32'h000000AA, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 2'd2, 32'h20, 32'h0,        1'b1, 32'h11AA3344};
        tbl[5]  = '{1'b1, 1'b0, 2'd2, 32'h24, 32'h0,        1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 2'd1, 32'h26, 32'h0000BEEF, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 32'h26, 32'h0,        1'b1, 32'h0000BEEF};
        tbl[8]  = '{1'b0, 1'b1, 2'd2, 32'h24, 32'h0,        1'b1, 32'hBEEF0000};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 32'h21, 32'h0,        1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 2'd2, 32'h22, 32'h0,        1'b0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 2'd3, 32'h20, 32'h0,        1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 32'h00010000, 32'h0,  1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 2'd2, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 1'b0, 2'd3, 32'h20, 32'hFFFFFFFF, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 2'd2, 32'h00010020, 32'h0,  1'b0, 32'h0};
        tbl[16] = '{1'b0, 1'b1, 2'd2, 32'h20, 32'h0,        1'b1, 32'h11AA3344};
        tbl[17] = '{1'b0, 1'b1, 2'd0, 32'h23, 32'h0,        1'b1, 32'h00000011};
        tbl[18] = '{1'b1, 1'b0, 2'd2, 32'h30, 32'h55667788, 1'b0, 32'h0};
        tbl[19] = '{1'b0, 1'b1, 2'd2, 32'h30, 32'h0,        1'b1, 32'h55667788};
        tbl[20] = '{1'b1, 1'b0, 2'd0, 32'h31, 32'h00000099, 1'b0, 32'h0};
        tbl[21] = '{1'b0, 1'b1, 2'd2, 32'h30, 32'h0,        1'b1, 32'h55669988};
        tbl[22] = '{1'b0, 1'b1, 2'd1, 32'h32, 32'h0,        1'b1, 32'h00005566};

        // Reset state
        @(negedge clk);
        check("rst_halt", {31'd0, bus.halt}, 32'd0);
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_rdata", bus.mem_rdata, 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 64; i++) begin
            acc(1'b1, 1'b0, 2'd2, 32'(i * 4), 32'd0);
        end

        for (int i = 0; i <= 22; i++) begin
            acc(tbl[i].we, tbl[i].re, tbl[i].sel, tbl[i].addr, tbl[i].wd);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_load", i), got_rd, tbl[i].exp);
            end
        end
        acc(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

        // Reset during the RMW cycle abandons the store and drops halt at once
        drive(1'b1, 1'b0, 2'd0, 32'h23, 32'h00000077);
        cyc(1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rmw_rst_halt", {31'd0, bus.halt}, 32'd0);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        @(negedge clk);
        check("rmw_rst_rdata", bus.mem_rdata, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        acc(1'b0, 1'b1, 2'd2, 32'h20, 32'd0);
        check("rmw_rst_preserved", got_rd, 32'h11AA3344);

        for (int n = 0; n < 400; n++) begin
            int          k;
            logic [31:0] a;
            k = int'($urandom_range(0, 9));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                a = a | 32'h0010_0000;
            end
            acc((k >= 4 && k <= 8), (k <= 3 || k == 8), 2'($urandom_range(0, 3)), a, $urandom);
        end
        acc(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        acc(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
